cfg_loader: RTL and testbench



---
 rtl/cfg_pkg.sv | 26 ++
 rtl/cfg_loader_if.sv | 24 ++
 rtl/cfg_shift_field.sv | 34 +++
 rtl/cfg_loader.sv | 145 ++++++++++++++
 tb/tb_cfg_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and defaults for the serial configuration loader
package cfg_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        DATA,
        PAR,
        WRITE,
        DONE
    } cfg_state_t;

    localparam logic [7:0] TILE_BASE       = 8'd0;
    localparam logic [7:0] SB_BASE         = 8'd8;
    localparam int         SB_COUNT        = 7;

    localparam logic [7:0] SYNC_DEF        = 8'hA5;
    localparam logic [7:0] END_ADDR_DEF    = 8'hFF;
    localparam int         NUM_TARGETS_DEF = int'(SB_BASE) + SB_COUNT;
    localparam int         FRAME_W_DEF     = 33;

    function automatic logic addr_in_map(input logic [7:0] a, input logic [7:0] n);
        return (a - TILE_BASE) < n;
    endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// rtl/cfg_loader_if.sv - bit-serial input and configuration write bus of the loader
interface cfg_loader_if #(
    parameter int FRAME_W = 33
);
    logic               cfg_din;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_we;
    logic [7:0]         cfg_addr;
    logic [FRAME_W-1:0] cfg_data;
    logic               cfg_done;
    logic               cfg_err;
    logic [7:0]         frame_cnt;

    modport master (
        output cfg_din, cfg_valid,
        input  cfg_ready, cfg_we, cfg_addr, cfg_data, cfg_done, cfg_err, frame_cnt
    );

    modport slave (
        input  cfg_din, cfg_valid,
        output cfg_ready, cfg_we, cfg_addr, cfg_data, cfg_done, cfg_err, frame_cnt
    );
endinterface

// File: rtl/cfg_shift_field.sv
// rtl/cfg_shift_field.sv - clearable MSB-first shift register with an accepted-bit counter
module cfg_shift_field #(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_shift,
    input  logic          i_din,
    output logic [W-1:0]  o_value,
    output logic [W-1:0]  o_next,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_value;
    logic [CW-1:0] r_count;

    assign o_next  = {r_value[W-2:0], i_din};
    assign o_value = r_value;
    assign o_count = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_value <= o_next;
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - frames a sync/addr/data/parity bitstream into addressed config writes
module cfg_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0] SYNC        = SYNC_DEF,
    parameter logic [7:0] END_ADDR    = END_ADDR_DEF,
    parameter int         NUM_TARGETS = NUM_TARGETS_DEF,
    parameter int         FRAME_W     = FRAME_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    cfg_loader_if.slave  bus
);
    localparam int DCW = $clog2(FRAME_W);

    cfg_state_t         r_state, w_next;
    logic [7:0]         r_addr;
    logic [FRAME_W-1:0] r_data;
    logic               r_err;
    logic [7:0]         r_cnt;

    logic               w_ready, w_xfer;
    logic               w_sh_hunt, w_sh_addr, w_sh_data;
    logic               w_clr_hunt, w_clr_addr, w_clr_data;
    logic               w_load, w_set_err, w_par;
    logic [7:0]         w_hunt_next, w_addr, w_addr_next_unused, w_hunt_unused;
    logic [2:0]         w_addr_cnt, w_hunt_cnt_unused;
    logic [FRAME_W-1:0] w_data, w_data_next_unused;
    logic [DCW-1:0]     w_data_cnt;

    assign w_ready    = (r_state == HUNT) || (r_state == ADDR) ||
                        (r_state == DATA) || (r_state == PAR);
    assign w_xfer     = bus.cfg_valid & w_ready;
    // Holding the hunt reg cleared outside HUNT stops a sync pattern straddling the last frame.
    assign w_clr_hunt = (r_state != HUNT);
    assign w_par      = ^{w_addr, w_data, bus.cfg_din};

    cfg_shift_field #(.W(8), .CW(3)) u_hunt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_clr_hunt),
        .i_shift (w_sh_hunt),
        .i_din   (bus.cfg_din),
        .o_value (w_hunt_unused),
        .o_next  (w_hunt_next),
        .o_count (w_hunt_cnt_unused)
    );

    cfg_shift_field #(.W(8), .CW(3)) u_addr (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_clr_addr),
        .i_shift (w_sh_addr),
        .i_din   (bus.cfg_din),
        .o_value (w_addr),
        .o_next  (w_addr_next_unused),
        .o_count (w_addr_cnt)
    );

    cfg_shift_field #(.W(FRAME_W), .CW(DCW)) u_data (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_clr_data),
        .i_shift (w_sh_data),
        .i_din   (bus.cfg_din),
        .o_value (w_data),
        .o_next  (w_data_next_unused),
        .o_count (w_data_cnt)
    );

    always_comb begin
        w_next     = r_state;
        w_sh_hunt  = 1'b0;
        w_sh_addr  = 1'b0;
        w_sh_data  = 1'b0;
        w_clr_addr = 1'b0;
        w_clr_data = 1'b0;
        w_load     = 1'b0;
        w_set_err  = 1'b0;
        case (r_state)
            HUNT: if (w_xfer) begin
                w_sh_hunt = 1'b1;
                if (w_hunt_next == SYNC) begin
                    w_next     = ADDR;
                    w_clr_addr = 1'b1;
                end
            end
            ADDR: if (w_xfer) begin
                w_sh_addr = 1'b1;
                if (w_addr_cnt == 3'd7) begin
                    w_next     = DATA;
                    w_clr_data = 1'b1;
                end
            end
            DATA: if (w_xfer) begin
                w_sh_data = 1'b1;
                if (w_data_cnt == DCW'(FRAME_W - 1)) w_next = PAR;
            end
            PAR: if (w_xfer) begin
                if (w_par) begin
                    w_set_err = 1'b1;
                    w_next    = HUNT;
                end else if (w_addr == END_ADDR) begin
                    w_next = DONE;
                end else if (!addr_in_map(w_addr, NUM_TARGETS[7:0])) begin
                    w_set_err = 1'b1;
                    w_next    = HUNT;
                end else begin
                    w_load = 1'b1;
                    w_next = WRITE;
                end
            end
            WRITE:   w_next = HUNT;
            DONE:    w_next = DONE;
            default: w_next = HUNT;
        endcase
    end

    // Outputs load on entry to WRITE so they are already valid while the strobe is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_err) r_err <= 1'b1;
            if (w_load) begin
                r_addr <= w_addr;
                r_data <= w_data;
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.cfg_ready = w_ready;
    assign bus.cfg_we    = (r_state == WRITE);
    assign bus.cfg_done  = (r_state == DONE);
    assign bus.cfg_addr  = r_addr;
    assign bus.cfg_data  = r_data;
    assign bus.cfg_err   = r_err;
    assign bus.frame_cnt = r_cnt;
endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - directed self-checking bench for cfg_loader
module tb_cfg_loader;
    import cfg_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   we_cnt   = 0;
    int   ready_bad = 0;
    int   w0;

    cfg_loader_if bus();

    cfg_loader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.cfg_we === 1'b1) begin
            we_cnt++;
            if (bus.cfg_ready !== 1'b0) ready_bad++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.cfg_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.cfg_valid = 1'b0;
        bus.cfg_din   = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap_pct);
        logic r;
        int   waited;
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.cfg_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        bus.cfg_din   = b;
        bus.cfg_valid = 1'b1;
        waited = 0;
        r = 1'b0;
        while (!r) begin
            r = bus.cfg_ready;
            @(posedge clock);
            #1;
            waited++;
            if (!r && waited > 100) begin
                n_assert++;
                n_fail++;
                $error("FAIL send_bit_timeout: observed ready=0 for %0d cycles expected ready=1", waited);
                r = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_pct);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap_pct);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [32:0] d, input logic flip, input int gap_pct);
        send_byte(SYNC_DEF, gap_pct);
        send_byte(a, gap_pct);
        for (int i = 32; i >= 0; i--) send_bit(d[i], gap_pct);
        send_bit((^{a, d}) ^ flip, gap_pct);
    endtask

    initial begin
        bus.cfg_din   = 1'b0;
        bus.cfg_valid = 1'b0;
        #1;
        check("rst_ready", bus.cfg_ready, 1);
        check("rst_we", bus.cfg_we, 0);
        check("rst_addr", bus.cfg_addr, 0);
        check("rst_data", bus.cfg_data, 0);
        check("rst_done", bus.cfg_done, 0);
        check("rst_err", bus.cfg_err, 0);
        check("rst_cnt", bus.frame_cnt, 0);
        do_reset();

        // Single good frame; addr 03 + data 1_8000_0001 holds five ones, so parity bit is 1.
        w0 = we_cnt;
        send_frame(8'h03, 33'h1_8000_0001, 1'b0, 0);
        check("t1_we_latency", bus.cfg_we, 1);
        check("t1_ready_in_write", bus.cfg_ready, 0);
        check("t1_addr_at_strobe", bus.cfg_addr, 8'h03);
        idle(3);
        check("t1_we_count", we_cnt - w0, 1);
        check("t1_addr", bus.cfg_addr, 8'h03);
        check("t1_data", bus.cfg_data, 33'h1_8000_0001);
        check("t1_cnt", bus.frame_cnt, 1);
        check("t1_err", bus.cfg_err, 0);
        check("t1_we_low", bus.cfg_we, 0);

        do_reset();
        w0 = we_cnt;
        send_frame(8'h03, 33'h1_8000_0001, 1'b1, 0);
        check("t2_no_we", bus.cfg_we, 0);
        idle(3);
        check("t2_we_count", we_cnt - w0, 0);
        check("t2_err", bus.cfg_err, 1);
        check("t2_cnt", bus.frame_cnt, 0);
        check("t2_addr_hold", bus.cfg_addr, 0);
        send_frame(8'h09, 33'h0_0000_ABCD, 1'b0, 0);
        idle(3);
        check("t2b_we_count", we_cnt - w0, 1);
        check("t2b_addr", bus.cfg_addr, 8'h09);
        check("t2b_data", bus.cfg_data, 33'h0_0000_ABCD);
        check("t2b_err_sticky", bus.cfg_err, 1);
        check("t2b_cnt", bus.frame_cnt, 1);

        do_reset();
        w0 = we_cnt;
        send_byte(8'h5A, 30);
        send_byte(8'h4B, 30);
        send_frame(8'h05, 33'h0_DEAD_BEEF, 1'b0, 30);
        idle(3);
        check("t3_we_count", we_cnt - w0, 1);
        check("t3_addr", bus.cfg_addr, 8'h05);
        check("t3_data", bus.cfg_data, 33'h0_DEAD_BEEF);
        check("t3_err", bus.cfg_err, 0);
        check("t3_cnt", bus.frame_cnt, 1);

        do_reset();
        w0 = we_cnt;
        send_frame(8'h0F, 33'h1_2345_6789, 1'b0, 0);
        idle(3);
        check("t4_bad_addr_we", we_cnt - w0, 0);
        check("t4_bad_addr_err", bus.cfg_err, 1);
        send_frame(8'hFF, 33'h0_0000_0000, 1'b0, 0);
        check("t4_done", bus.cfg_done, 1);
        check("t4_done_ready", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.cfg_din = i[0];
            @(posedge clock);
            #1;
        end
        check("t4_done_sticky", bus.cfg_done, 1);
        check("t4_ignored_we", we_cnt - w0, 0);
        check("t4_ignored_cnt", bus.frame_cnt, 0);
        check("t4_ignored_addr", bus.cfg_addr, 0);

        do_reset();
        w0 = we_cnt;
        send_byte(SYNC_DEF, 0);
        send_byte(8'h02, 0);
        begin
            logic [32:0] d5;
            d5 = 33'h0_0000_1234;
            for (int i = 32; i >= 13; i--) send_bit(d5[i], 0);
            reset = 1'b1;
            #2;
            check("t5_ready", bus.cfg_ready, 1);
            check("t5_we", bus.cfg_we, 0);
            check("t5_addr", bus.cfg_addr, 0);
            check("t5_data", bus.cfg_data, 0);
            check("t5_cnt", bus.frame_cnt, 0);
            check("t5_err", bus.cfg_err, 0);
            check("t5_done", bus.cfg_done, 0);
            @(posedge clock);
            #1 reset = 1'b0;
            for (int i = 12; i >= 0; i--) send_bit(d5[i], 0);
            send_bit(^{8'h02, d5}, 0);
        end
        idle(3);
        check("t5_no_we", we_cnt - w0, 0);
        check("t5_cnt_after", bus.frame_cnt, 0);

        do_reset();
        w0 = we_cnt;
        ready_bad = 0;
        for (int f = 0; f < 256; f++) begin
            logic [7:0] fb;
            fb = f[7:0];
            send_frame(8'(f % 15), {1'b1, 16'hC0DE, fb, ~fb}, 1'b0, 0);
            if (f == 254) check("t6_cnt_255_frames", bus.frame_cnt, 8'hFF);
        end
        idle(3);
        check("t6_we_count", we_cnt - w0, 256);
        check("t6_cnt_sat", bus.frame_cnt, 8'hFF);
        check("t6_ready_in_write", ready_bad, 0);
        check("t6_last_addr", bus.cfg_addr, 8'h00);
        check("t6_last_data", bus.cfg_data, {1'b1, 16'hC0DE, 8'hFF, 8'h00});
        check("t6_err", bus.cfg_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
